// File: rtl/store_buffer.sv
// store_buffer: in-order pending-store FIFO ahead of datamemory with word-granular load hazard stall.
// Define STORE_FWD_EN to forward youngest matching SW data to LW loads instead of stalling.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [DM_ADDRESS-1:0]     st_addr,
    input  logic [DATA_W-1:0]         st_data,
    input  logic [2:0]                st_funct3,
    input  logic                      ld_valid,
    input  logic [DM_ADDRESS-1:0]     ld_addr,
    input  logic [2:0]                ld_funct3,
    output logic                      ld_stall,
    output logic                      dm_MemWrite,
    output logic [DM_ADDRESS-1:0]     dm_a,
    output logic [DATA_W-1:0]         dm_wd,
    output logic [2:0]                dm_Funct3,
    output logic [$clog2(DEPTH):0]    sb_count,
`ifdef STORE_FWD_EN
    output logic                      sb_empty,
    output logic                      ld_fwd_valid,
    output logic [DATA_W-1:0]         ld_fwd_data
`else
    output logic                      sb_empty
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DM_ADDRESS-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [2:0]            f3_q   [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0]         count_q, count_d;
    logic                  acc, drn, hit, fwd, y_sw;
    logic [DATA_W-1:0]     y_data;
    logic                  unused_ok;

    // Walk entries oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit    = 1'b0;
        y_sw   = 1'b0;
        y_data = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q && addr_q[idx][DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2]) begin
                hit    = 1'b1;
                y_sw   = f3_q[idx] == 3'b010;
                y_data = data_q[idx];
            end
        end
        hit = hit && ld_valid && reset;
    end

`ifdef STORE_FWD_EN
    assign fwd          = hit && y_sw && ld_funct3 == 3'b010;
    assign ld_fwd_valid = fwd;
    assign ld_fwd_data  = y_data;
`else
    assign fwd = 1'b0;
`endif

    assign st_ready    = reset && count_q < CW'(DEPTH);
    assign ld_stall    = hit && !fwd;
    assign acc         = st_valid && st_ready;
    assign drn         = reset && count_q != '0 && (!ld_valid || ld_stall);
    assign dm_MemWrite = drn;
    assign dm_a        = addr_q[head_q];
    assign dm_wd       = data_q[head_q];
    assign dm_Funct3   = f3_q[head_q];
    assign sb_count    = reset ? count_q : '0;
    assign sb_empty    = sb_count == '0;
    assign unused_ok   = &{1'b0, ld_addr[1:0], ld_funct3, y_sw, y_data};

    always_comb begin
        head_d  = head_q + PW'(drn);
        tail_d  = tail_q + PW'(acc);
        count_d = count_q + CW'(acc) - CW'(drn);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            f3_q[tail_q]   <= st_funct3;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios for store_buffer; fills, drains, hazards, wrap and reset.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready;
    logic [8:0]  st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        ld_valid;
    logic [8:0]  ld_addr;
    logic [2:0]  ld_funct3;
    logic        ld_stall, dm_MemWrite;
    logic [8:0]  dm_a;
    logic [31:0] dm_wd;
    logic [2:0]  dm_Funct3;
    logic [2:0]  sb_count;
    logic        sb_empty;
`ifdef STORE_FWD_EN
    logic        ld_fwd_valid;
    logic [31:0] ld_fwd_data;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_stall(ld_stall), .dm_MemWrite(dm_MemWrite), .dm_a(dm_a),
        .dm_wd(dm_wd), .dm_Funct3(dm_Funct3), .sb_count(sb_count),
`ifdef STORE_FWD_EN
        .sb_empty(sb_empty), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data)
`else
        .sb_empty(sb_empty)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f);
        st_valid  = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f;
    endtask

    task automatic test_reset();
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0;
        tick(); tick();
        #1;
        tests++; if (sb_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", sb_empty); end
        tests++; if (st_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", st_ready); end
        tests++; if (dm_MemWrite !== 1'b0) begin fails++; $display("FAIL reset_memwrite got %b exp 0", dm_MemWrite); end
        tests++; if (sb_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", sb_count); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_drain_order();
        logic [8:0]  ea [3] = '{9'h010, 9'h014, 9'h018};
        logic [31:0] ed [3] = '{32'hA, 32'hB, 32'hC};
        for (int k = 0; k < 4; k++) begin
            if (k < 3) store(ea[k], ed[k], 3'b010); else st_valid = 1'b0;
            #1;
            if (k == 0) begin
                tests++; if (dm_MemWrite !== 1'b0) begin fails++; $display("FAIL order_first_idle got %b exp 0", dm_MemWrite); end
            end else begin
                tests++; if (dm_MemWrite !== 1'b1 || dm_a !== ea[k-1] || dm_wd !== ed[k-1])
                    begin fails++; $display("FAIL order_drain%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", k, dm_MemWrite, dm_a, dm_wd, ea[k-1], ed[k-1]); end
            end
            tick();
        end
        #1;
        tests++; if (dm_MemWrite !== 1'b0 || sb_empty !== 1'b1) begin fails++; $display("FAIL order_done got we=%b empty=%b exp 0 1", dm_MemWrite, sb_empty); end
    endtask

    task automatic test_fill();
        ld_valid = 1'b1; ld_addr = 9'h100; ld_funct3 = 3'b010;
        for (int k = 0; k < 4; k++) begin
            store(9'h030 + 9'(4 * k), 32'(k + 1), 3'b010);
            #1;
            tests++; if (dm_MemWrite !== 1'b0 || ld_stall !== 1'b0) begin fails++; $display("FAIL fill_nodrain%0d got we=%b stall=%b exp 0 0", k, dm_MemWrite, ld_stall); end
            tick();
        end
        store(9'h040, 32'h5, 3'b010);
        #1;
        tests++; if (sb_count !== 3'd4 || st_ready !== 1'b0) begin fails++; $display("FAIL fill_full got cnt=%0d rdy=%b exp 4 0", sb_count, st_ready); end
        tick();
        st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        tests++; if (sb_count !== 3'd4) begin fails++; $display("FAIL fill_fifth got cnt=%0d exp 4", sb_count); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (dm_MemWrite !== 1'b1 || dm_a !== 9'h030 + 9'(4 * k) || dm_wd !== 32'(k + 1))
                begin fails++; $display("FAIL fill_drain%0d got we=%b a=%h d=%h exp a=%h d=%h", k, dm_MemWrite, dm_a, dm_wd, 9'h030 + 9'(4 * k), k + 1); end
            tick();
        end
        #1;
        tests++; if (sb_empty !== 1'b1 || dm_MemWrite !== 1'b0) begin fails++; $display("FAIL fill_empty got empty=%b we=%b exp 1 0", sb_empty, dm_MemWrite); end
    endtask

    task automatic test_hazard();
        ld_valid = 1'b1; ld_addr = 9'h100; ld_funct3 = 3'b010;
        store(9'h060, 32'h66, 3'b010); tick();
        store(9'h021, 32'h55, 3'b000); tick();
        st_valid = 1'b0; ld_addr = 9'h020;
        #1;
        tests++; if (ld_stall !== 1'b1 || dm_MemWrite !== 1'b1 || dm_a !== 9'h060) begin fails++; $display("FAIL haz_first got stall=%b we=%b a=%h exp 1 1 060", ld_stall, dm_MemWrite, dm_a); end
        tick();
        tests++; if (ld_stall !== 1'b1 || dm_MemWrite !== 1'b1 || dm_a !== 9'h021 || dm_Funct3 !== 3'b000)
            begin fails++; $display("FAIL haz_sb got stall=%b we=%b a=%h f3=%b exp 1 1 021 000", ld_stall, dm_MemWrite, dm_a, dm_Funct3); end
        tick();
        tests++; if (ld_stall !== 1'b0 || dm_MemWrite !== 1'b0) begin fails++; $display("FAIL haz_clear got stall=%b we=%b exp 0 0", ld_stall, dm_MemWrite); end
        ld_valid = 1'b0;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 7; k++) begin
            if (k < 6) store(9'h080 + 9'(4 * k), 32'h100 + 32'(k), 3'b010); else st_valid = 1'b0;
            #1;
            tests++; if (sb_count !== (k == 0 ? 3'd0 : 3'd1)) begin fails++; $display("FAIL wrap_count%0d got %0d exp %0d", k, sb_count, k == 0 ? 0 : 1); end
            if (k > 0) begin
                tests++; if (dm_MemWrite !== 1'b1 || dm_a !== 9'h080 + 9'(4 * (k - 1)) || dm_wd !== 32'h100 + 32'(k - 1))
                    begin fails++; $display("FAIL wrap_drain%0d got we=%b a=%h d=%h", k, dm_MemWrite, dm_a, dm_wd); end
            end
            tick();
        end
        #1;
        tests++; if (sb_empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", sb_empty); end
    endtask

    task automatic test_reset_pending();
        ld_valid = 1'b1; ld_addr = 9'h100;
        for (int k = 0; k < 3; k++) begin store(9'h0C0 + 9'(4 * k), 32'h77, 3'b010); tick(); end
        st_valid = 1'b0; ld_valid = 1'b0; reset = 1'b0;
        #1;
        tests++; if (dm_MemWrite !== 1'b0 || st_ready !== 1'b0 || sb_count !== 3'd0) begin fails++; $display("FAIL rstp_held got we=%b rdy=%b cnt=%0d exp 0 0 0", dm_MemWrite, st_ready, sb_count); end
        tick();
        reset = 1'b1;
        #1;
        tests++; if (sb_count !== 3'd0 || dm_MemWrite !== 1'b0 || st_ready !== 1'b1) begin fails++; $display("FAIL rstp_after got cnt=%0d we=%b rdy=%b exp 0 0 1", sb_count, dm_MemWrite, st_ready); end
        tick();
        tests++; if (dm_MemWrite !== 1'b0 || sb_empty !== 1'b1) begin fails++; $display("FAIL rstp_stale got we=%b empty=%b exp 0 1", dm_MemWrite, sb_empty); end
    endtask

`ifdef STORE_FWD_EN
    task automatic test_fwd();
        store(9'h040, 32'hDEADBEEF, 3'b010); ld_valid = 1'b1; ld_addr = 9'h100; tick();
        st_valid = 1'b0; ld_addr = 9'h040; ld_funct3 = 3'b010;
        #1;
        tests++; if (ld_stall !== 1'b0 || ld_fwd_valid !== 1'b1 || ld_fwd_data !== 32'hDEADBEEF || dm_MemWrite !== 1'b0)
            begin fails++; $display("FAIL fwd_lw got stall=%b fv=%b fd=%h we=%b", ld_stall, ld_fwd_valid, ld_fwd_data, dm_MemWrite); end
        ld_funct3 = 3'b000;
        #1;
        tests++; if (ld_stall !== 1'b1 || ld_fwd_valid !== 1'b0 || dm_MemWrite !== 1'b1) begin fails++; $display("FAIL fwd_lb got stall=%b fv=%b we=%b exp 1 0 1", ld_stall, ld_fwd_valid, dm_MemWrite); end
        tick();
        ld_valid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_drain_order();
        test_fill();
        test_hazard();
        test_wrap();
        test_reset_pending();
`ifdef STORE_FWD_EN
        test_fwd();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO of pending stores, placed directly upstream of datamemory in the MEM stage.
- Accepts SB/SH/SW requests from the pipeline and retires them one per cycle into the datamemory write port.
- Loads always have port priority; drains use cycles not taken by a load.
- Detects loads that touch a word with a pending store and stalls them (or forwards, with the optional feature) so memory ordering is preserved.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- DM_ADDRESS, 9, address width, matching datamemory.
- DATA_W, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- st_valid  input  1  store request from the pipeline.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  DM_ADDRESS  store byte address.
- st_data  input  DATA_W  store data.
- st_funct3  input  3  store width code: 000 SB, 001 SH, 010 SW.
- ld_valid  input  1  load in MEM stage this cycle.
- ld_addr  input  DM_ADDRESS  load byte address.
- ld_funct3  input  3  load width code.
- ld_stall  output  1  load must be held; pipeline freezes MEM and earlier stages.
- dm_MemWrite  output  1  write strobe to datamemory.
- dm_a  output  DM_ADDRESS  write address to datamemory.
- dm_wd  output  DATA_W  write data to datamemory.
- dm_Funct3  output  3  write width to datamemory.
- sb_count  output  $clog2(DEPTH)+1  number of valid entries.
- sb_empty  output  1  high when sb_count == 0.

Behaviour:
- Storage: circular array of DEPTH entries {addr, data, funct3}; head pointer, tail pointer, occupancy counter.
- Reset (reset == 0 at a clock edge):
  - head, tail and count all go to 0; stored entry contents are don't-care.
  - Anything in flight is discarded, including a mid-operation drain or accept.
  - Outputs while held in reset: st_ready = 0, ld_stall = 0, dm_MemWrite = 0, sb_count = 0, sb_empty = 1.
- Accept:
  - st_ready = (count < DEPTH), registered-state based only; it does not depend on a same-cycle drain.
  - st_valid && st_ready writes the entry at tail; tail increments modulo DEPTH.
  - The entry becomes visible to drain and hazard logic on the next cycle. Latency is one cycle minimum from accept to dm_MemWrite.
- Hazard:
  - hit = ld_valid && any valid entry has addr[DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2]. Matching is at word granularity, regardless of width.
  - ld_stall = hit. It is combinational from current state and ld inputs.
  - A store accepted in the same cycle is not checked; the pipeline never presents a load and a store in one cycle.
- Drain:
  - drain = (count != 0) && (!ld_valid || ld_stall).
  - When drain: dm_MemWrite = 1 and dm_a/dm_wd/dm_Funct3 = head entry, all combinational.
  - On the clock edge, head increments modulo DEPTH.
  - A stalled load therefore frees the port, and the buffer drains until the hit clears; no deadlock is possible.
- Simultaneous accept and drain: count is unchanged and both pointers advance.
- Accept only: count +1. Drain only: count −1.
- Pointer wrap: tail at DEPTH−1 followed by an accept wraps to 0; head wraps the same way.
- Stores retire in program order. No coalescing.
- When not draining: dm_MemWrite = 0; dm_a, dm_wd and dm_Funct3 hold the head entry values (don't-care).

Optional Feature:
- STORE_FWD_EN
  - Defined: on a hit where the youngest matching entry is SW and ld_funct3 is LW, the load does not stall.
    - Extra outputs ld_fwd_valid (1 bit) and ld_fwd_data (DATA_W) are added.
    - ld_fwd_valid = 1 and ld_fwd_data = that entry's data.
    - ld_stall = 0 in this case, so drain is blocked that cycle.
    - All other hits stall as in the base behaviour.
  - Undefined: ld_fwd_* ports do not exist, and every hit stalls.

Test Plan:
- Reset → sb_empty = 1, st_ready = 0 while reset = 0. After release, three SW to 0x010/0x014/0x018 with data 0xA/0xB/0xC and no loads → dm_MemWrite pulses on three consecutive cycles, starting the cycle after the first accept, in address order.
- Fill with 4 SW while ld_valid = 1 on non-matching address 0x100 → no drain; st_ready = 0 after 4th; sb_count = 4. A 5th st_valid is not accepted. Drop ld_valid → 4 drains, then sb_empty = 1.
- Pending SB to 0x021; LW from 0x020 → ld_stall = 1 until the SB drains. ld_stall is 0 the cycle after dm_MemWrite with dm_a = 0x021.
- Wrap: 6 accept/drain pairs interleaved one per cycle → pointers wrap; data order is preserved; sb_count never exceeds 1.
- Reset asserted with 3 entries pending → next cycle sb_count = 0 and dm_MemWrite = 0; the stale entries are never written.
- STORE_FWD_EN: pending SW 0xDEADBEEF to 0x040, LW 0x040 → ld_stall = 0, ld_fwd_valid = 1, ld_fwd_data = 0xDEADBEEF, no drain that cycle. Same scenario with LB → stall.
